// File: rtl/line_window_buffer.sv
// Raster-to-column converter: emits each valid pixel with the four pixels above it,
// using four chained line buffers and a fixed 2-cycle pipeline for data and control.
module line_window_buffer #(
  parameter int LINE_W = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_i,
  input  logic        dv_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [39:0] pixel_data_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(LINE_W - 1);

  logic [ADDR_W-1:0] col_q, col_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        line_cnt_q, line_cnt_d;
  logic              dv_prev_q, vs_prev_q;
  logic              dv_fall, vs_rise;

  logic [7:0]        s1_pix_q;
  logic              s1_dv_q, s1_hs_q, s1_vs_q, s1_valid_q;
  logic [2:0]        s1_cnt_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic [31:0]       rd_w;
  logic [39:0]       chain_w;
  logic              wr_en;
  logic [39:0]       data_d;

  // ovf_q marks that the column index has run past the last buffer slot.
  always_comb begin
    dv_fall    = dv_prev_q & ~dv_i;
    vs_rise    = vs_i & ~vs_prev_q;
    col_d      = col_q;
    ovf_d      = ovf_q;
    line_cnt_d = line_cnt_q;
    if (vs_rise || dv_fall) begin
      col_d = '0;
      ovf_d = 1'b0;
    end else if (dv_i) begin
      if (col_q == COL_MAX) ovf_d = 1'b1;
      else                  col_d = col_q + 1'b1;
    end
    if (vs_rise)                             line_cnt_d = 3'd0;
    else if (dv_fall && line_cnt_q != 3'd4) line_cnt_d = line_cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      ovf_q      <= 1'b0;
      line_cnt_q <= 3'd0;
      dv_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      s1_pix_q   <= 8'd0;
      s1_dv_q    <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= 3'd0;
      s1_addr_q  <= '0;
    end else begin
      col_q      <= col_d;
      ovf_q      <= ovf_d;
      line_cnt_q <= line_cnt_d;
      dv_prev_q  <= dv_i;
      vs_prev_q  <= vs_i;
      s1_pix_q   <= pixel_i;
      s1_dv_q    <= dv_i;
      s1_hs_q    <= hs_i;
      s1_vs_q    <= vs_i;
      s1_valid_q <= ~ovf_q;
      s1_cnt_q   <= line_cnt_q;
      s1_addr_q  <= col_q;
    end
  end

  // Write data for LBk is what LB(k-1) held at this column; LB0 takes the new pixel.
  assign chain_w = {rd_w, s1_pix_q};
  assign wr_en   = s1_dv_q & s1_valid_q;

  for (genvar g = 0; g < 4; g++) begin : g_lb
    logic [7:0] mem [LINE_W];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (!rst && dv_i) rd_q <= mem[col_q];
      if (wr_en)        mem[s1_addr_q] <= chain_w[8*g +: 8];
    end
    assign rd_w[8*g +: 8] = rd_q;
  end

  always_comb begin
    data_d = '0;
    if (s1_dv_q) begin
      data_d[7:0] = s1_pix_q;
      for (int k = 1; k < 5; k++) begin
        if (s1_valid_q && (s1_cnt_q >= 3'(k))) data_d[8*k +: 8] = rd_w[8*(k-1) +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_data_o <= 40'd0;
      dv_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
    end else begin
      pixel_data_o <= data_d;
      dv_o         <= s1_dv_q;
      hs_o         <= s1_hs_q;
      vs_o         <= s1_vs_q;
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer (LINE_W=8): each step queues its hand-computed
// output word and checks it two clocks later against {dv_o,hs_o,vs_o,pixel_data_o}.
module tb_line_window_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_i;
  logic        dv_i, hs_i, vs_i;
  logic [39:0] pixel_data_o;
  logic        dv_o, hs_o, vs_o;

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;
  logic [42:0] exp_q[$];
  logic [39:0] ev;

  always #5 clk = ~clk;

  line_window_buffer #(.LINE_W(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_i      (pixel_i),
    .dv_i         (dv_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .pixel_data_o (pixel_data_o),
    .dv_o         (dv_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  // One clock of stimulus; output observed now belongs to the previous step's input.
  task automatic step(input logic r, input logic [7:0] pix, input logic dv,
                      input logic hs, input logic vs, input logic [39:0] exp_data);
    logic [42:0] e;
    logic [42:0] got;
    rst = r; pixel_i = pix; dv_i = dv; hs_i = hs; vs_i = vs;
    if (r) exp_q.delete();
    exp_q.push_back(r ? 43'd0 : {dv, hs, vs, (dv ? exp_data : 40'd0)});
    @(posedge clk);
    #1;
    step_no++;
    got = {dv_o, hs_o, vs_o, pixel_data_o};
    if (r || exp_q.size() >= 2) begin
      e = r ? 43'd0 : exp_q.pop_front();
      checks++;
      assert (got[42:40] === e[42:40]) else begin
        failures++;
        $error("FAIL step%0d ctrl observed=%b expected=%b", step_no, got[42:40], e[42:40]);
      end
      checks++;
      assert (got[39:0] === e[39:0]) else begin
        failures++;
        $error("FAIL step%0d data observed=%h expected=%h", step_no, got[39:0], e[39:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; pixel_i = 8'd0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;

    // reset held with active input, then first pixel after release
    repeat (3) step(1, 8'hAA, 1, 0, 0, 40'd0);
    step(0, 8'hAA, 1, 0, 0, 40'h00_00_00_00_AA);
    step(0, 8'h00, 0, 1, 0, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);

    // first line of a frame: 8 pixels 1..8, no upper rows
    step(0, 8'h00, 0, 0, 1, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 8; c++) step(0, 8'(c + 1), 1, 0, 0, {32'h0, 8'(c + 1)});
    step(0, 8'h00, 0, 1, 0, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);

    // five lines of width 4, single-cycle gaps, pixel = 16*line + col
    step(0, 8'h00, 0, 0, 1, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int l = 0; l < 5; l++) begin
      for (int c = 0; c < 4; c++) begin
        ev = '0;
        for (int k = 0; k < 5; k++) if (l >= k) ev[8*k +: 8] = 8'(16 * (l - k) + c);
        step(0, 8'(16 * l + c), 1, 0, 0, ev);
      end
      step(0, 8'h00, 0, 0, 0, 40'd0);
    end

    // new frame over stale RAM
    step(0, 8'h00, 0, 0, 1, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 4; c++) step(0, 8'h77, 1, 0, 0, 40'h00_00_00_00_77);
    step(0, 8'h00, 0, 0, 0, 40'd0);

    // overflow: 10-pixel lines into an 8-deep buffer
    step(0, 8'h00, 0, 0, 1, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 10; c++) step(0, 8'h11, 1, 0, 0, 40'h00_00_00_00_11);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 10; c++)
      step(0, 8'h22, 1, 0, 0, (c < 8) ? 40'h00_00_00_11_22 : 40'h00_00_00_00_22);
    step(0, 8'h00, 0, 0, 0, 40'd0);

    // dv_i fall coincides with vs_i rise: line count must clear
    for (int c = 0; c < 3; c++) step(0, 8'h55, 1, 0, 0, 40'h00_00_11_22_55);
    step(0, 8'h00, 0, 0, 1, 40'd0);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 3; c++) step(0, 8'h66, 1, 0, 0, 40'h00_00_00_00_66);
    step(0, 8'h00, 0, 0, 0, 40'd0);
    for (int c = 0; c < 3; c++) step(0, 8'h99, 1, 0, 0, 40'h00_00_00_66_99);
    repeat (3) step(0, 8'h00, 0, 0, 0, 40'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
